fp_reduction_tree_adder: RTL and testbench
==========================================

Name: fp_reduction_tree_adder

Overview:
- Parametrised, pipelined-by-level reduction of NI IEEE-754 single-precision inputs to one 32-bit sum.
- Successor to the fixed-width 128/64/… adder trees: one module for any NI ≥ 2, including non-power-of-two NI.
- Adds an explicit ready/busy handshake, an optional running accumulator across successive vectors, and asynchronous reset.
- Sits between the per-element multiply stage and the dot-product/vector-sum consumers.

Parameters:
- NI, 128, number of 32-bit float inputs (≥ 2; non-power-of-two allowed).
- ADD_LAT, 2, fixed latency of one pair adder, start to done, in cycles (≥ 1).
- LEVELS, $clog2(NI), tree depth; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when ready=1.
- acc_en  in  1  sampled with start; add the tree result into the accumulator.
- acc_clr  in  1  sampled with start; zero the accumulator before this vector's result is added.
- inputs  in  NI*32  packed floats; element i occupies inputs[32*(NI-i)-1 -: 32], so element 0 is the MSB word.
- ready  out  1  idle; start will be accepted.
- summation  out  32  tree sum, or accumulator value when acc_en was set; held until the next done.
- done  out  1  one-cycle pulse when summation updates.
- acc_value  out  32  current accumulator register.

Behaviour:
- Reset (asynchronous, any state):
  - ready=1, done=0, summation=0, acc_value=0.
  - All level registers, done-barrier bits and the level counter clear.
  - An in-flight operation is discarded with no done pulse.
  - ready is high in the first cycle after rst deasserts.
- FSM states:
  - IDLE: on start & ready, capture inputs, acc_en and acc_clr, then go to RUN with level=0.
  - RUN: issue a one-cycle start to every pair adder of the current level. Each adder's done sets a sticky barrier bit. When all bits of the level are set, register the level outputs, clear the barrier and increment level. After level LEVELS-1 go to ACC if acc_en, else DONE.
  - ACC: one pair add of the accumulator (or +0.0 if acc_clr) with the tree result; write the accumulator on completion; go to DONE.
  - DONE: register summation, pulse done for one cycle, return to IDLE (ready=1 in that same cycle).
- Padding: level j has ceil(n_j/2) adders, where n_0=NI and n_{j+1}=ceil(n_j/2). An odd trailing element is paired with +0.0 (0x00000000), so all levels have uniform latency.
- Latency, start sampled at edge T0:
  - Level j start pulses at T0+1+j*(ADD_LAT+1).
  - done is high in cycle T0+LEVELS*(ADD_LAT+1)+1, or +(ADD_LAT+1) more with acc_en.
  - Fixed and data-independent.
- start while ready=0 is ignored; no queuing, no error flag.
- acc_clr without acc_en:
  - The accumulator is zeroed when the tree result completes.
  - summation carries the plain tree sum.
- Arithmetic: round-to-nearest-even, as in the pair adder. NaN/Inf propagate per the pair adder; no extra flags.
- inputs are sampled only at the accepting edge. Changes afterwards do not affect the result.

Decomposition:
- Shared package fp_pkg holds:
  - FP_W=32 and FP_ZERO=32'h0000_0000.
  - A function returning the pair count of level j for a given NI.
- One sub-module, fp_pair_add:
  - Ports: clk, rst, start, a, b, result, done.
  - Fixed ADD_LAT.
  - Wraps the team's existing single-precision adder_subtractor_with_start in add mode.
- The tree is built by a generate over levels with per-level barrier registers.

Test Plan:
- NI=8, ADD_LAT=2, inputs 1.0..8.0, start at T0 → done in cycle T0+10, summation=0x42100000 (36.0), ready=0 from T0+1 to T0+9.
- NI=5, inputs 1.0..5.0 → summation=0x41700000 (15.0); done at T0+3*3+1=T0+10 (LEVELS=3).
- NI=8, vector 1..8 with acc_en=1, acc_clr=1, then again with acc_en=1, acc_clr=0 → acc_value/summation 0x42100000 then 0x42900000 (72.0); each done at T0+13.
- Pulse start again at T0+4 with different inputs → ignored; first result 0x42100000 unchanged; exactly one done pulse.
- Assert rst at T0+5 for one cycle → done never pulses, outputs 0, ready=1 the cycle after release; a new start gives a correct sum.
- Inputs {+1.0, -1.0, 2.5, -2.5, 0x7F800000, …} → zero-cancelling pairs give 0x00000000; an Inf element gives summation=0x7F800000.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared float width, zero constant, FSM states and tree sizing helpers
package fp_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACC, S_DONE} state_t;
  function automatic int elem_cnt(input int ni, input int j);
    int n;
    n = ni;
    for (int k = 0; k < j; k++) n = (n + 1) / 2;
    return n;
  endfunction
  function automatic int pair_cnt(input int ni, input int j);
    return (elem_cnt(ni, j) + 1) / 2;
  endfunction
endpackage

// File: rtl/fp_pair_add.sv
// fp_pair_add: single-precision pair adder, round-to-nearest-even, fixed start-to-done latency
module fp_pair_add
  import fp_pkg::*;
#(
  parameter int ADD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result,
  output logic            done
);
  logic [FP_W-1:0] res_q, res_d;
  logic [ADD_LAT-1:0] sr_q, sr_d;
  function automatic logic [31:0] fp_add(input logic [31:0] a_i, input logic [31:0] b_i);
    logic [31:0] x, y;
    logic [26:0] mx, my;
    logic [27:0] s;
    logic [24:0] r;
    logic a_nan, b_nan, a_inf, b_inf, found;
    int ex, ey, d, e, lz, sh;
    a_nan = (&a_i[30:23]) && (|a_i[22:0]);
    b_nan = (&b_i[30:23]) && (|b_i[22:0]);
    a_inf = (&a_i[30:23]) && !(|a_i[22:0]);
    b_inf = (&b_i[30:23]) && !(|b_i[22:0]);
    x = a_i[30:0] >= b_i[30:0] ? a_i : b_i;
    y = a_i[30:0] >= b_i[30:0] ? b_i : a_i;
    ex = x[30:23] == 8'd0 ? 1 : int'(x[30:23]);
    ey = y[30:23] == 8'd0 ? 1 : int'(y[30:23]);
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};
    d = ex - ey;
    my = d > 26 ? {26'd0, |my} : (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
    s = x[31] == y[31] ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
    e = ex;
    lz = 0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (s[i]) found = 1'b1;
        else lz++;
      end
    end
    sh = lz < e - 1 ? lz : e - 1;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e++;
    end else begin
      s = s << sh;
      e -= sh;
    end
    r = {1'b0, s[26:3]} + 25'(s[2] & (s[1] | s[0] | s[3]));
    if (r[24]) begin
      r = r >> 1;
      e++;
    end
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return a_i[31] == b_i[31] ? a_i : 32'h7FC0_0000;
    if (a_inf) return a_i;
    if (b_inf) return b_i;
    if (s == 28'd0) return {x[31] & y[31], 31'd0};
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], r[23] ? 8'(e) : 8'd0, r[22:0]};
  endfunction
  // compute the sum on start and hold it; a shift register times the done pulse
  always_comb begin
    res_d = start ? fp_add(a, b) : res_q;
    sr_d = ADD_LAT'({sr_q, start});
  end
  // result and latency pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= FP_ZERO;
      sr_q <= '0;
    end else begin
      res_q <= res_d;
      sr_q <= sr_d;
    end
  end
  assign result = res_q;
  assign done = sr_q[ADD_LAT-1];
endmodule

// File: rtl/fp_reduction_tree_adder.sv
// fp_reduction_tree_adder: level-by-level float reduction tree with optional running accumulator
module fp_reduction_tree_adder
  import fp_pkg::*;
#(
  parameter int NI = 128,
  parameter int ADD_LAT = 2,
  localparam int LEVELS = $clog2(NI)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               acc_en,
  input  logic               acc_clr,
  input  logic [NI*FP_W-1:0] inputs,
  output logic               ready,
  output logic [FP_W-1:0]    summation,
  output logic               done,
  output logic [FP_W-1:0]    acc_value
);
  localparam int LVW = $clog2(LEVELS + 1);
  state_t state_q, state_d;
  logic [LVW-1:0] level_q, level_d;
  logic issue_q, issue_d, acc_en_q, acc_en_d, acc_clr_q, acc_clr_d;
  logic [FP_W-1:0] sum_q, sum_d, acc_q, acc_d, tree_res, acc_res;
  logic [FP_W-1:0] lvl_res [LEVELS][NI];
  logic [LEVELS-1:0] lvl_done;
  logic accept, acc_done, last;
  assign ready = state_q == S_IDLE || state_q == S_DONE;
  assign done = state_q == S_DONE;
  assign accept = start && ready;
  assign last = level_q == LVW'(LEVELS - 1);
  assign tree_res = lvl_res[LEVELS-1][0];
  assign summation = sum_q;
  assign acc_value = acc_q;
  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int N = elem_cnt(NI, j);
    localparam int P = pair_cnt(NI, j);
    logic [FP_W-1:0] vals_q [N];
    logic [FP_W-1:0] vals_d [N];
    logic [P-1:0] bar_q, bar_d, pdone;
    logic active;
    assign active = state_q == S_RUN && level_q == LVW'(j);
    assign lvl_done[j] = active && &(bar_q | pdone);
    if (j == 0) begin : g_in
      // level 0 captures the input vector only at the accepting edge
      always_comb for (int i = 0; i < N; i++) vals_d[i] = accept ? inputs[FP_W*(NI-i)-1 -: FP_W] : vals_q[i];
    end else begin : g_in
      // deeper levels load the previous level's sums once that level completes
      always_comb for (int i = 0; i < N; i++) vals_d[i] = lvl_done[j-1] ? lvl_res[j-1][i] : vals_q[i];
    end
    // sticky done barrier, cleared as the level completes
    always_comb bar_d = lvl_done[j] ? '0 : bar_q | pdone;
    // level operand and barrier registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vals_q <= '{default: FP_ZERO};
        bar_q <= '0;
      end else begin
        vals_q <= vals_d;
        bar_q <= bar_d;
      end
    end
    for (genvar p = 0; p < NI; p++) begin : g_pair
      if (p < P) begin : g_add
        logic [FP_W-1:0] b_op;
        if (2 * p + 1 < N) begin : g_b
          assign b_op = vals_q[2*p+1];
        end else begin : g_b
          assign b_op = FP_ZERO;
        end
        fp_pair_add #(.ADD_LAT(ADD_LAT)) u_add (
          .clk   (clk),
          .rst   (rst),
          .start (active && issue_q),
          .a     (vals_q[2*p]),
          .b     (b_op),
          .result(lvl_res[j][p]),
          .done  (pdone[p])
        );
      end else begin : g_pad
        assign lvl_res[j][p] = FP_ZERO;
      end
    end
  end
  fp_pair_add #(.ADD_LAT(ADD_LAT)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == S_ACC && issue_q),
    .a     (acc_clr_q ? FP_ZERO : acc_q),
    .b     (tree_res),
    .result(acc_res),
    .done  (acc_done)
  );
  // next-state, level sequencing and result/accumulator updates
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    issue_d = 1'b0;
    acc_en_d = acc_en_q;
    acc_clr_d = acc_clr_q;
    sum_d = sum_q;
    acc_d = acc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = accept ? S_RUN : S_IDLE;
        level_d = accept ? '0 : level_q;
        issue_d = accept;
        acc_en_d = accept ? acc_en : acc_en_q;
        acc_clr_d = accept ? acc_clr : acc_clr_q;
      end
      S_RUN: begin
        if (|lvl_done) begin
          state_d = !last ? S_RUN : acc_en_q ? S_ACC : S_DONE;
          level_d = last ? level_q : level_q + LVW'(1);
          issue_d = !last || acc_en_q;
          sum_d = last && !acc_en_q ? tree_res : sum_q;
          acc_d = last && !acc_en_q && acc_clr_q ? FP_ZERO : acc_q;
        end
      end
      S_ACC: begin
        state_d = acc_done ? S_DONE : S_ACC;
        sum_d = acc_done ? acc_res : sum_q;
        acc_d = acc_done ? acc_res : acc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      level_q <= '0;
      issue_q <= 1'b0;
      acc_en_q <= 1'b0;
      acc_clr_q <= 1'b0;
      sum_q <= FP_ZERO;
      acc_q <= FP_ZERO;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      issue_q <= issue_d;
      acc_en_q <= acc_en_d;
      acc_clr_q <= acc_clr_d;
      sum_q <= sum_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_fp_reduction_tree_adder.sv
// tb_fp_reduction_tree_adder: directed vectors with a done-driven scoreboard on NI=8 and NI=5 trees
module tb_fp_reduction_tree_adder;
  typedef logic [31:0] vec8_t [8];
  typedef struct {logic [31:0] sum; logic [31:0] acc; int t;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, start5 = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
  logic [255:0] in8 = '0;
  logic [159:0] in5 = '0;
  logic ready8, done8, ready5, done5;
  logic [31:0] sum8, accv8, sum5, accv5;
  int cyc = 1;
  int n_cmp = 0, n_bad = 0;
  exp_t q8[$], q5[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fp_reduction_tree_adder #(.NI(8), .ADD_LAT(2)) u8 (
    .clk(clk), .rst(rst), .start(start8), .acc_en(acc_en), .acc_clr(acc_clr), .inputs(in8),
    .ready(ready8), .summation(sum8), .done(done8), .acc_value(accv8)
  );
  fp_reduction_tree_adder #(.NI(5), .ADD_LAT(2)) u5 (
    .clk(clk), .rst(rst), .start(start5), .acc_en(1'b0), .acc_clr(1'b0), .inputs(in5),
    .ready(ready5), .summation(sum5), .done(done5), .acc_value(accv5)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask
  // scoreboard monitors: every done pulse must match the oldest expected result
  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) chk("u8 unexpected done", 32'(q8.size()), 32'd1);
      else begin
        e = q8.pop_front();
        chk("u8 summation", sum8, e.sum);
        chk("u8 acc_value", accv8, e.acc);
        chk("u8 done cycle", 32'(cyc), 32'(e.t));
      end
    end
  end
  always @(negedge clk) begin : mon5
    exp_t e;
    if (!rst && done5) begin
      if (q5.size() == 0) chk("u5 unexpected done", 32'(q5.size()), 32'd1);
      else begin
        e = q5.pop_front();
        chk("u5 summation", sum5, e.sum);
        chk("u5 done cycle", 32'(cyc), 32'(e.t));
      end
    end
  end
  task automatic run8(input vec8_t v, input logic ae, input logic ac, input logic [31:0] es, input logic [31:0] ea, input bit poke);
    int lat, t0;
    lat = ae ? 13 : 10;
    @(negedge clk);
    for (int i = 0; i < 8; i++) in8[32*(8-i)-1 -: 32] = v[i];
    start8 = 1'b1;
    acc_en = ae;
    acc_clr = ac;
    t0 = cyc;
    q8.push_back('{es, ea, t0 + lat});
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start8 = poke && k == 4;
      if (k == 1 || k == 4) in8 = {8{32'h4120_0000}};
      chk("u8 ready", {31'd0, ready8}, {31'd0, k == lat});
    end
    acc_en = 1'b0;
    acc_clr = 1'b0;
  endtask
  vec8_t v18, vmix, vcan, vinf, vtie, vrnd;
  initial begin
    v18 = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    vmix = '{32'h3FC0_0000, 32'h3E80_0000, 32'hBF00_0000, 32'h4040_0000, 32'h42C8_0000, 32'hC280_0000, 32'h3E00_0000, 32'h4120_0000};
    vcan = '{32'h3F80_0000, 32'hBF80_0000, 32'h4020_0000, 32'hC020_0000, 32'h0, 32'h0, 32'h0, 32'h0};
    vinf = '{32'h3F80_0000, 32'hBF80_0000, 32'h4020_0000, 32'hC020_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    vtie = '{32'h4B80_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vrnd = '{32'h4B80_0000, 32'h4040_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", {31'd0, ready8}, 32'd1);
    chk("reset done", {31'd0, done8}, 32'd0);
    chk("reset summation", sum8, 32'd0);
    chk("reset acc_value", accv8, 32'd0);
    run8(v18, 1'b0, 1'b0, 32'h4210_0000, 32'h0, 1'b0);
    run8(v18, 1'b0, 1'b0, 32'h4210_0000, 32'h0, 1'b1);
    run8(v18, 1'b1, 1'b1, 32'h4210_0000, 32'h4210_0000, 1'b0);
    run8(v18, 1'b1, 1'b0, 32'h4290_0000, 32'h4290_0000, 1'b0);
    run8(v18, 1'b0, 1'b1, 32'h4210_0000, 32'h0, 1'b0);
    run8(v18, 1'b1, 1'b1, 32'h4210_0000, 32'h4210_0000, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) in8[32*(8-i)-1 -: 32] = v18[i];
    start8 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      rst = k == 5;
      if (k == 7) begin
        chk("post-reset ready", {31'd0, ready8}, 32'd1);
        chk("post-reset summation", sum8, 32'd0);
        chk("post-reset acc_value", accv8, 32'd0);
      end
    end
    chk("post-reset no pending", 32'(q8.size()), 32'd0);
    run8(v18, 1'b0, 1'b0, 32'h4210_0000, 32'h0, 1'b0);
    run8(vmix, 1'b0, 1'b0, 32'h4249_8000, 32'h0, 1'b0);
    run8(vcan, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    run8(vinf, 1'b0, 1'b0, 32'h7F80_0000, 32'h0, 1'b0);
    run8(vtie, 1'b0, 1'b0, 32'h4B80_0000, 32'h0, 1'b0);
    run8(vrnd, 1'b0, 1'b0, 32'h4B80_0002, 32'h0, 1'b0);
    @(negedge clk);
    in5 = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    start5 = 1'b1;
    q5.push_back('{32'h4170_0000, 32'h0, cyc + 10});
    @(negedge clk);
    start5 = 1'b0;
    in5 = '0;
    repeat (20) @(negedge clk);
    chk("u8 queue drained", 32'(q8.size()), 32'd0);
    chk("u5 queue drained", 32'(q5.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
